// File: rtl/data_ram_responder_if.sv
// data_ram_responder_if: load/store memory port between the CPU MEM stage
// (master) and the data RAM responder (slave).
//   ce_i    request valid           we_i    1 = write, 0 = read
//   addr_i  byte address            sel_i   byte lane enables
//   data_i  write data              data_o  registered read data
//   ack_o   one-cycle completion    err_o   request rejected (with ack_o)
//   busy_o  responder holds an accepted request
interface data_ram_responder_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        err_o;
  logic        busy_o;

  modport master (
    output ce_i, we_i, addr_i, sel_i, data_i,
    input  data_o, ack_o, err_o, busy_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, sel_i, data_i,
    output data_o, ack_o, err_o, busy_o
  );
endinterface

// File: rtl/data_ram_responder.sv
// data_ram_responder: word-addressed data RAM answering the CPU load/store
// port. One request in flight; WAIT_CYCLES wait states between acceptance
// and a single-cycle ack (optionally with err).
//   clk  system clock, rising edge
//   rst  asynchronous reset, active-low
//   bus  data_ram_responder_if.slave (request in, ack/err/busy/data out)
// RAM contents are not reset.
module data_ram_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  data_ram_responder_if.slave   bus
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  sel_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        commit;
  logic        src_we;
  logic [31:0] src_addr;
  logic [3:0]  src_sel;
  logic [31:0] src_data;
  logic        src_err;
  logic [DEPTH_LOG2-1:0] src_idx;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ce_i) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access commits on the accepting edge itself,
  // before the latches hold the request, so the live inputs are used there.
  always_comb begin
    if (state_q == S_IDLE) begin
      src_we   = bus.we_i;
      src_addr = bus.addr_i;
      src_sel  = bus.sel_i;
      src_data = bus.data_i;
    end else begin
      src_we   = we_q;
      src_addr = addr_q;
      src_sel  = sel_q;
      src_data = wdata_q;
    end
    src_err = ((src_addr >> (DEPTH_LOG2 + 2)) != '0) ||
              (src_addr[1:0] != 2'b00) ||
              (src_we && (src_sel == 4'b0000));
  end

  assign src_idx = src_addr[DEPTH_LOG2+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.we_i;
        addr_q  <= bus.addr_i;
        sel_q   <= bus.sel_i;
        wdata_q <= bus.data_i;
        cnt_q   <= WAIT_INIT;
      end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit) begin
        err_q <= src_err;
        if (src_err) begin
          rdata_q <= '0;
        end else if (!src_we) begin
          rdata_q <= mem[src_idx];
        end
      end
    end
  end

  // Gated by rst so a request presented during reset can never write.
  always_ff @(posedge clk) begin
    if (rst && commit && src_we && !src_err) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (src_sel[k]) begin
          mem[src_idx][8*k +: 8] <= src_data[8*k +: 8];
        end
      end
    end
  end

  assign bus.ack_o  = (state_q == S_RESP);
  assign bus.err_o  = (state_q == S_RESP) && err_q;
  assign bus.busy_o = (state_q != S_IDLE);
  assign bus.data_o = rdata_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder: randomized self-checking bench for data_ram_responder.
// Two instances share clock and reset: one with WAIT_CYCLES=2 (main traffic)
// and one with WAIT_CYCLES=0 (ce held high across ack).
module tb_data_ram_responder;

  localparam int unsigned WAIT2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_ram_responder_if b2 ();
  data_ram_responder_if b0 ();

  data_ram_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(WAIT2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  data_ram_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference model for the WAIT_CYCLES=2 instance
  logic [31:0] m2 [1024];
  logic [31:0] exp2_data = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input bit we, input logic [31:0] addr, input logic [3:0] sel);
    return (addr >= 32'h1000) || (addr % 4 != 0) || (we && sel == 4'b0000);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (sel[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // Called just after the accepting edge; waits for ack (bounded), checks
  // latency, err and data, then checks the following IDLE cycle.
  task automatic finish2(input string tag, input int exp_lat, input bit exp_err,
                         input logic [31:0] exp_data);
    int lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(b2.busy_o), 32'd1);
      if (b2.ack_o) begin
        lat = k;
        b2.ce_i = 1'b0;
      end else begin
        // inputs are ignored while waiting
        b2.ce_i   = 1'($urandom % 2);
        b2.we_i   = 1'($urandom % 2);
        b2.addr_i = $urandom;
        b2.sel_i  = 4'($urandom);
        b2.data_i = $urandom;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (lat != 0) begin
      check({tag, "_err"}, 32'(b2.err_o), 32'(exp_err));
      check({tag, "_data"}, b2.data_o, exp_data);
    end
    b2.ce_i = 1'b0;
    @(negedge clk);
    check({tag, "_ackfall"}, {30'd0, b2.ack_o, b2.busy_o}, 32'd0);
    check({tag, "_errlow"}, 32'(b2.err_o), 32'd0);
  endtask

  task automatic model_apply(input bit we, input logic [31:0] addr, input logic [3:0] sel,
                             input logic [31:0] data, output bit err);
    err = model_err(we, addr, sel);
    if (err) exp2_data = 32'h0;
    else if (we) m2[addr / 4] = merge(m2[addr / 4], data, sel);
    else exp2_data = m2[addr / 4];
  endtask

  // Must be called at a falling edge.
  task automatic req2(input string tag, input bit we, input logic [31:0] addr,
                      input logic [3:0] sel, input logic [31:0] data);
    bit err;
    b2.ce_i = 1'b1; b2.we_i = we; b2.addr_i = addr; b2.sel_i = sel; b2.data_i = data;
    model_apply(we, addr, sel, data, err);
    @(posedge clk);
    finish2(tag, WAIT2 + 1, err, exp2_data);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit err;
    b2.ce_i = 1'b1; b2.we_i = 1'b1; b2.addr_i = '0; b2.sel_i = '0; b2.data_i = '0;
    b0.ce_i = 1'b1; b0.we_i = 1'b1; b0.addr_i = '0; b0.sel_i = '0; b0.data_i = '0;

    // reset held with ce high
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_ctl2", {29'd0, b2.ack_o, b2.err_o, b2.busy_o}, 32'd0);
      check("rst_data2", b2.data_o, 32'd0);
      check("rst_ctl0", {29'd0, b0.ack_o, b0.err_o, b0.busy_o}, 32'd0);
    end
    rst = 1'b1;
    model_apply(1'b1, 32'h0, 4'b0000, 32'h0, err);
    @(posedge clk);
    @(negedge clk);
    check("rel_busy2", 32'(b2.busy_o), 32'd1);
    check("rel_ack0", {29'd0, b0.ack_o, b0.err_o, b0.busy_o}, 32'd7);
    b0.ce_i = 1'b0;
    b2.ce_i = 1'b0;
    finish2("rel2", WAIT2, err, exp2_data);

    // fill the low region so later reads have defined contents
    for (int w = 0; w < 64; w++)
      req2("init", 1'b1, 32'(w * 4), 4'b1111, $urandom);

    req2("wr10", 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF);
    req2("rd10", 1'b0, 32'h10, 4'b0000, 32'h0);
    check("rd10_const", b2.data_o, 32'hDEADBEEF);
    req2("byte10", 1'b1, 32'h10, 4'b0100, 32'h00AA0000);
    req2("rdbyte", 1'b0, 32'h10, 4'b1111, 32'h0);
    check("rdbyte_const", b2.data_o, 32'hDEAABEEF);
    req2("rd1000", 1'b0, 32'h1000, 4'b1111, 32'h0);
    req2("wr12", 1'b1, 32'h12, 4'b1111, 32'h11111111);
    req2("rd10b", 1'b0, 32'h10, 4'b0000, 32'h0);
    check("rd10b_const", b2.data_o, 32'hDEAABEEF);
    req2("sel0", 1'b1, 32'h14, 4'b0000, 32'h22222222);
    req2("wrtop", 1'b1, 32'hFFC, 4'b1111, 32'hCAFEF00D);
    req2("rdtop", 1'b0, 32'hFFC, 4'b0000, 32'h0);

    // reset during WAIT drops the pending write
    b2.ce_i = 1'b1; b2.we_i = 1'b1; b2.addr_i = 32'h20; b2.sel_i = 4'b1111;
    b2.data_i = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    b2.ce_i = 1'b0;
    exp2_data = 32'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("midrst_ctl", {29'd0, b2.ack_o, b2.err_o, b2.busy_o}, 32'd0);
      check("midrst_data", b2.data_o, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    req2("rd20", 1'b0, 32'h20, 4'b0000, 32'h0);

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      logic [31:0] a;
      int unsigned r;
      r = $urandom % 10;
      a = 32'(($urandom % 64) * 4);
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = a | (32'd1 << $urandom_range(12, 31));
      req2("rand", 1'($urandom % 2), a, 4'($urandom), $urandom);
    end

    // WAIT_CYCLES=0 with ce held high across ack
    b0.ce_i = 1'b1; b0.we_i = 1'b1; b0.addr_i = 32'h10; b0.sel_i = 4'b1111;
    b0.data_i = 32'h55;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("held_ack0", 32'(b0.ack_o), 32'(k % 2));
      check("held_busy0", 32'(b0.busy_o), 32'(k % 2));
      if (k == 1) b0.we_i = 1'b0;
      if (k > 1 && (k % 2) == 1) check("held_data0", b0.data_o, 32'h55);
    end
    b0.ce_i = 1'b0;
    @(negedge clk);
    check("held_end0", {30'd0, b0.ack_o, b0.busy_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
